// File: rtl/tc2sm_pkg.sv
// tc2sm shared types: FSM states, chunk count helper, defaults.
// Imported by tc2sm_serial.
package tc2sm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } tc2sm_state_e;

  localparam int W_DEF     = 49;
  localparam int CHUNK_DEF = 8;

  function automatic int nchunk(input int w, input int c);
    return (w + c - 1) / c;
  endfunction

endpackage

// File: rtl/tc2sm_chunk_inc.sv
// CHUNK-bit slice of the serial negator: {cout,sum} = (neg ? ~a : a) + cin.
// Ports: a_i, neg_i, cin_i in; sum_o, cout_o out. Purely combinational.
module tc2sm_chunk_inc #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic             neg_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK-1:0] op;

  assign op = neg_i ? ~a_i : a_i;
  assign {cout_o, sum_o} = {1'b0, op} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/tc2sm_serial.sv
// Serial two's-complement -> sign-magnitude converter, CHUNK bits/cycle.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready,
// out_sign, out_mag, out_minneg (only with TC2SM_MINNEG_FLAG_EN).
module tc2sm_serial
  import tc2sm_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
`ifdef TC2SM_MINNEG_FLAG_EN
  output logic         out_minneg,
`endif
  output logic [W-1:0] out_mag
);

  localparam int NCH = nchunk(W, CHUNK);
  localparam int WP  = NCH * CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  // async assert, sync deassert of the internal reset
  logic [1:0] rs_q;
  logic       rst_in_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rs_q <= 2'b00;
    else        rs_q <= {rs_q[0], 1'b1};
  end

  assign rst_in_n = rs_q[1];

  tc2sm_state_e    state_q, state_d;
  logic [WP-1:0]   x_q, x_d;
  logic [WP-1:0]   r_q, r_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            neg_q, neg_d;
  logic            cy_q, cy_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    mag_q, mag_d;
`ifdef TC2SM_MINNEG_FLAG_EN
  logic            mn_q, mn_d;
  logic            omn_q, omn_d;
`endif

  logic [CHUNK-1:0] sum;
  logic             cout;
  logic [WP-1:0]    r_nx;
  logic             last;

  tc2sm_chunk_inc #(.CHUNK(CHUNK)) u_inc (
    .a_i   (x_q[CHUNK-1:0]),
    .neg_i (neg_q),
    .cin_i (cy_q),
    .sum_o (sum),
    .cout_o(cout)
  );

  // result enters at the top, so after NCH shifts chunk 0 sits at bit 0
  assign r_nx = (r_q >> CHUNK) | (WP'(sum) << (WP - CHUNK));
  assign last = (idx_q == IW'(NCH - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    idx_d   = idx_q;
    neg_d   = neg_q;
    cy_d    = cy_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
`ifdef TC2SM_MINNEG_FLAG_EN
    mn_d    = mn_q;
    omn_d   = omn_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (in_valid) begin
          x_d     = WP'(in_data);
          r_d     = '0;
          idx_d   = '0;
          neg_d   = in_data[W-1];
          cy_d    = in_data[W-1];
`ifdef TC2SM_MINNEG_FLAG_EN
          mn_d    = (in_data == (W'(1) << (W - 1)));
`endif
          state_d = BUSY;
        end
      end
      (state_q == BUSY): begin
        x_d   = x_q >> CHUNK;
        r_d   = r_nx;
        cy_d  = cout;
        idx_d = idx_q + IW'(1);
        if (last) begin
          sign_d  = neg_q;
          mag_d   = r_nx[W-1:0];
`ifdef TC2SM_MINNEG_FLAG_EN
          omn_d   = mn_q;
`endif
          state_d = DONE;
        end
      end
      (state_q == DONE): begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      neg_q   <= 1'b0;
      cy_q    <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
`ifdef TC2SM_MINNEG_FLAG_EN
      mn_q    <= 1'b0;
      omn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      cy_q    <= cy_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
`ifdef TC2SM_MINNEG_FLAG_EN
      mn_q    <= mn_d;
      omn_q   <= omn_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = sign_q;
  assign out_mag   = mag_q;
`ifdef TC2SM_MINNEG_FLAG_EN
  assign out_minneg = omn_q;
`endif

endmodule

// File: tb/tb_tc2sm_serial.sv
// Bench for tc2sm_serial: directed W=8/CHUNK=3 cases and random
// W=49/CHUNK=8 operands against an arithmetic reference.
module tb_tc2sm_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, os8;
  logic [7:0] id8 = '0, om8;
  logic        iv49 = 1'b0, ir49, ov49, or49 = 1'b0, os49;
  logic [48:0] id49 = '0, om49;
`ifdef TC2SM_MINNEG_FLAG_EN
  logic mn8, mn49;
`endif

  tc2sm_serial #(.W(8), .CHUNK(3)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_sign(os8),
`ifdef TC2SM_MINNEG_FLAG_EN
    .out_minneg(mn8),
`endif
    .out_mag(om8)
  );

  tc2sm_serial #(.W(49), .CHUNK(8)) u49 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv49), .in_ready(ir49), .in_data(id49),
    .out_valid(ov49), .out_ready(or49), .out_sign(os49),
`ifdef TC2SM_MINNEG_FLAG_EN
    .out_minneg(mn49),
`endif
    .out_mag(om49)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [7:0] x, input logic es,
                       input logic [7:0] em, input logic emn,
                       input string tag);
    int t;
    int lat;
    t = 0;
    while (!ir8 && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_rdy"}, 64'(ir8), 64'd1);
    iv8 = 1'b1; id8 = x;
    @(negedge clk);
    iv8 = 1'b0; id8 = $urandom;
    lat = 0;
    while (!ov8 && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_sign"}, 64'(os8), 64'(es));
    chk({tag, "_mag"}, 64'(om8), 64'(em));
`ifdef TC2SM_MINNEG_FLAG_EN
    chk({tag, "_mn"}, 64'(mn8), 64'(emn));
`else
    if (emn) ;
`endif
  endtask

  task automatic hs8(input string tag);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk({tag, "_hs_ov"}, 64'(ov8), 64'd0);
    chk({tag, "_hs_ir"}, 64'(ir8), 64'd1);
  endtask

  task automatic run49(input logic [48:0] x);
    logic        es;
    logic [48:0] em;
    int t;
    int lat;
    int st;
    es = x[48];
    em = es ? (49'd0 - x) : x;
    t = 0;
    while (!ir49 && t < 50) begin @(negedge clk); t++; end
    chk("r49_rdy", 64'(ir49), 64'd1);
    iv49 = 1'b1; id49 = x;
    @(negedge clk);
    iv49 = 1'b0; id49 = {$urandom, $urandom};
    lat = 0;
    while (!ov49 && lat < 30) begin @(negedge clk); lat++; end
    chk("r49_lat", 64'(lat), 64'd7);
    st = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
    repeat (st) @(negedge clk);
    chk("r49_ov", 64'(ov49), 64'd1);
    chk("r49_sign", 64'(os49), 64'(es));
    chk("r49_mag", 64'(om49), 64'(em));
`ifdef TC2SM_MINNEG_FLAG_EN
    chk("r49_mn", 64'(mn49), 64'(x == (49'd1 << 48)));
`endif
    or49 = 1'b1;
    @(negedge clk);
    or49 = 1'b0;
    chk("r49_hs", 64'(ov49), 64'd0);
  endtask

  initial begin
    #1;
    chk("rst_ir", 64'(ir8), 64'd1);
    chk("rst_ov", 64'(ov8), 64'd0);
    chk("rst_sign", 64'(os8), 64'd0);
    chk("rst_mag", 64'(om8), 64'd0);
`ifdef TC2SM_MINNEG_FLAG_EN
    chk("rst_mn", 64'(mn8), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send8(8'hF6, 1'b1, 8'h0A, 1'b0, "neg10");
    hs8("neg10");
    send8(8'h80, 1'b1, 8'h80, 1'b1, "minneg");
    hs8("minneg");

    send8(8'h00, 1'b0, 8'h00, 1'b0, "zero");
    iv8 = 1'b1; id8 = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bb_ir_lo", 64'(ir8), 64'd0);
      chk("bb_mag_hold", 64'(om8), 64'd0);
    end
    iv8 = 1'b0;
    hs8("zero");
    send8(8'h7F, 1'b0, 8'h7F, 1'b0, "max");
    hs8("max");

    send8(8'hFF, 1'b1, 8'h01, 1'b0, "m1");
    for (int i = 0; i < 10; i++) begin
      iv8 = 1'b1; id8 = $urandom;
      @(negedge clk);
      chk("bp_ov", 64'(ov8), 64'd1);
      chk("bp_ir", 64'(ir8), 64'd0);
      chk("bp_sign", 64'(os8), 64'd1);
      chk("bp_mag", 64'(om8), 64'd1);
    end
    iv8 = 1'b0;
    hs8("m1");

    iv8 = 1'b1; id8 = 8'h55;
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", 64'(ov8), 64'd0);
    chk("mrst_ir", 64'(ir8), 64'd1);
    chk("mrst_sign", 64'(os8), 64'd0);
    chk("mrst_mag", 64'(om8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mrst_noout", 64'(ov8), 64'd0);
    send8(8'hC0, 1'b1, 8'h40, 1'b0, "c0");
    hs8("c0");

    run49(49'h1_0000_0000_0000);
    run49('1);
    run49('0);
    run49(49'h0_FFFF_FFFF_FFFF);
    run49(49'h1_0000_0000_0001);
    for (int i = 0; i < 3000; i++) begin
      logic [48:0] x;
      x = 49'({$urandom, $urandom});
      run49(x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
